// File: rtl/calc_mem_responder_if.sv
// rtl/calc_mem_responder_if.sv - read/write request bus between a requester and calc_mem_responder
interface calc_mem_responder_if #(
  parameter int ADDR_W        = 10,
  parameter int MEM_WORD_SIZE = 64
);
  // Requests are active-low: read/write low asks for service this cycle.
  logic                     read;
  logic [ADDR_W-1:0]        r_addr;
  logic [MEM_WORD_SIZE-1:0] r_data;
  logic                     r_valid;
  logic                     write;
  logic [ADDR_W-1:0]        w_addr;
  logic [MEM_WORD_SIZE-1:0] w_data;

  modport master (
    output read, r_addr, write, w_addr, w_data,
    input  r_data, r_valid
  );

  modport slave (
    input  read, r_addr, write, w_addr, w_data,
    output r_data, r_valid
  );
endinterface

// File: rtl/calc_mem_responder.sv
// rtl/calc_mem_responder.sv - word memory with post-reset clear sweep, counters and sticky errors (CALC_MEM_RD_FWD_EN: write-first same-address reads)
module calc_mem_responder #(
  parameter int ADDR_W        = 10,
  parameter int MEM_WORD_SIZE = 64,
  parameter int DEPTH         = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  calc_mem_responder_if.slave   mem_if,
  output logic                  busy_o,
  output logic [1:0]            err_o,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count
);

  // Index width covers exactly the implemented words; the wider bus address
  // is only used for the range check.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_L   = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_ADDR = IDX_W'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [IDX_W-1:0]         clr_addr;
  logic [MEM_WORD_SIZE-1:0] mem [DEPTH];

  logic                     rd_req;
  logic                     wr_req;
  logic                     rd_in_range;
  logic                     wr_in_range;
  logic                     ready;
  logic                     rd_ok;
  logic                     wr_ok;
  logic                     rd_oob;
  logic                     wr_oob;
  logic                     busy_req;
  logic [IDX_W-1:0]         rd_idx;
  logic [IDX_W-1:0]         wr_idx;
  logic [MEM_WORD_SIZE-1:0] rd_word;
  logic [MEM_WORD_SIZE-1:0] r_data_q;
  logic                     r_valid_q;
  logic [1:0]               err_q;
  logic [15:0]              rd_cnt_q;
  logic [15:0]              wr_cnt_q;

  assign rd_req      = ~mem_if.read;
  assign wr_req      = ~mem_if.write;
  assign rd_in_range = {1'b0, mem_if.r_addr} < DEPTH_L;
  assign wr_in_range = {1'b0, mem_if.w_addr} < DEPTH_L;
  assign rd_idx      = mem_if.r_addr[IDX_W-1:0];
  assign wr_idx      = mem_if.w_addr[IDX_W-1:0];
  assign ready       = (state == S_READY);

  // Requests only take effect in S_READY; during the sweep they only flag an error.
  assign rd_ok    = ready & rd_req & rd_in_range;
  assign wr_ok    = ready & wr_req & wr_in_range;
  assign rd_oob   = ready & rd_req & ~rd_in_range;
  assign wr_oob   = ready & wr_req & ~wr_in_range;
  assign busy_req = ~ready & (rd_req | wr_req);

  // State register; reset always restarts the clear sweep.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: leave S_CLEAR right after the last word has been zeroed.
  always_comb begin
    state_nxt = state;
    busy_o    = 1'b0;
    case (state)
      S_CLEAR: begin
        busy_o = 1'b1;
        if (clr_addr == LAST_ADDR) begin
          state_nxt = S_READY;
        end
      end
      S_READY: begin
        state_nxt = S_READY;
      end
      default: begin
        state_nxt = S_CLEAR;
      end
    endcase
  end

  // Sweep pointer walks 0..DEPTH-1, one word per cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clr_addr <= '0;
    end else if (state == S_CLEAR) begin
      clr_addr <= clr_addr + 1'b1;
    end
  end

  // Memory array: zeroed by the sweep, then written by accepted requests.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state == S_CLEAR) begin
        mem[clr_addr] <= '0;
      end else if (wr_ok) begin
        mem[wr_idx] <= mem_if.w_data;
      end
    end
  end

  // Read word selection; same-address collisions either see the old word or the incoming data.
  always_comb begin
    rd_word = mem[rd_idx];
`ifdef CALC_MEM_RD_FWD_EN
    if (wr_ok && (mem_if.w_addr == mem_if.r_addr)) begin
      rd_word = mem_if.w_data;
    end
`else
    rd_word = mem[rd_idx];
`endif
  end

  // Registered read response; out-of-range reads still respond, with zero data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_data_q  <= '0;
      r_valid_q <= 1'b0;
    end else begin
      r_valid_q <= ready & rd_req;
      if (ready && rd_req) begin
        r_data_q <= rd_in_range ? rd_word : '0;
      end
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 2'b00;
    end else begin
      if (rd_oob || wr_oob) begin
        err_q[0] <= 1'b1;
      end
      if (busy_req) begin
        err_q[1] <= 1'b1;
      end
    end
  end

  // Saturating counters of accepted in-range accesses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (rd_ok && (rd_cnt_q != 16'hFFFF)) begin
        rd_cnt_q <= rd_cnt_q + 16'd1;
      end
      if (wr_ok && (wr_cnt_q != 16'hFFFF)) begin
        wr_cnt_q <= wr_cnt_q + 16'd1;
      end
    end
  end

  assign mem_if.r_data  = r_data_q;
  assign mem_if.r_valid = r_valid_q;
  assign err_o          = err_q;
  assign rd_count       = rd_cnt_q;
  assign wr_count       = wr_cnt_q;

endmodule

// File: tb/tb_calc_mem_responder.sv
// tb/tb_calc_mem_responder.sv - directed self-checking bench for calc_mem_responder
module tb_calc_mem_responder;
  localparam int ADDR_W = 11;
  localparam int W      = 64;
  localparam int DEPTH  = 1024;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        busy_o;
  logic [1:0]  err_o;
  logic [15:0] rd_count;
  logic [15:0] wr_count;
  int          checks = 0;
  int          passed = 0;

  always #5 clk_i = ~clk_i;

  calc_mem_responder_if #(.ADDR_W(ADDR_W), .MEM_WORD_SIZE(W)) mem_if ();

  calc_mem_responder #(.ADDR_W(ADDR_W), .MEM_WORD_SIZE(W), .DEPTH(DEPTH)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .mem_if   (mem_if),
    .busy_o   (busy_o),
    .err_o    (err_o),
    .rd_count (rd_count),
    .wr_count (wr_count)
  );

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle;
    mem_if.read   = 1'b1;
    mem_if.write  = 1'b1;
    mem_if.r_addr = '0;
    mem_if.w_addr = '0;
    mem_if.w_data = '0;
  endtask

  task automatic do_reset;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic wait_sweep(output int n);
    n = 0;
    while (busy_o && n < 2000) begin
      n++;
      tick();
    end
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a);
    mem_if.read = 1'b0; mem_if.r_addr = a;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [W-1:0] d);
    mem_if.write = 1'b0; mem_if.w_addr = a; mem_if.w_data = d;
  endtask

  task automatic test_reset;
    idle();
    do_reset();
    checks++; if (busy_o !== 1'b1) $display("FAIL reset_busy: got %b expected 1", busy_o); else passed++;
    checks++; if (mem_if.r_valid !== 1'b0) $display("FAIL reset_r_valid: got %b expected 0", mem_if.r_valid); else passed++;
    checks++; if (mem_if.r_data !== 64'h0) $display("FAIL reset_r_data: got %h expected 0", mem_if.r_data); else passed++;
    checks++; if (err_o !== 2'b00) $display("FAIL reset_err: got %b expected 00", err_o); else passed++;
    checks++; if (rd_count !== 16'd0 || wr_count !== 16'd0) $display("FAIL reset_counts: got %0d/%0d expected 0/0", rd_count, wr_count); else passed++;
  endtask

  task automatic test_sweep;
    int n;
    wait_sweep(n);
    checks++; if (n != 1024) $display("FAIL sweep_len: got %0d expected 1024", n); else passed++;
    checks++; if (busy_o !== 1'b0) $display("FAIL sweep_done_busy: got %b expected 0", busy_o); else passed++;
    rd(5); tick(); idle();
    checks++; if (mem_if.r_valid !== 1'b1) $display("FAIL read5_valid: got %b expected 1", mem_if.r_valid); else passed++;
    checks++; if (mem_if.r_data !== 64'h0) $display("FAIL read5_data: got %h expected 0", mem_if.r_data); else passed++;
    checks++; if (rd_count !== 16'd1) $display("FAIL read5_count: got %0d expected 1", rd_count); else passed++;
    tick();
    checks++; if (mem_if.r_valid !== 1'b0) $display("FAIL read5_pulse: got %b expected 0", mem_if.r_valid); else passed++;
  endtask

  task automatic test_write_read;
    int n;
    do_reset();
    wait_sweep(n);
    checks++; if (n != 1024) $display("FAIL sweep2_len: got %0d expected 1024", n); else passed++;
    wr(3, 64'hDEAD_BEEF_0000_0001); tick(); idle();
    rd(3); tick(); idle();
    checks++; if (mem_if.r_data !== 64'hDEAD_BEEF_0000_0001) $display("FAIL wr_rd3_data: got %h expected deadbeef00000001", mem_if.r_data); else passed++;
    checks++; if (mem_if.r_valid !== 1'b1) $display("FAIL wr_rd3_valid: got %b expected 1", mem_if.r_valid); else passed++;
    checks++; if (rd_count !== 16'd1 || wr_count !== 16'd1) $display("FAIL wr_rd3_counts: got %0d/%0d expected 1/1", rd_count, wr_count); else passed++;
    tick();
    checks++; if (mem_if.r_data !== 64'hDEAD_BEEF_0000_0001 || mem_if.r_valid !== 1'b0) $display("FAIL hold_data: got %h/%b expected deadbeef00000001/0", mem_if.r_data, mem_if.r_valid); else passed++;
    wr(1023, 64'hA5A5); tick(); idle();
    rd(1023); tick(); idle();
    checks++; if (mem_if.r_data !== 64'hA5A5) $display("FAIL last_word: got %h expected a5a5", mem_if.r_data); else passed++;
  endtask

  task automatic test_same_addr;
    logic [W-1:0] exp_fwd;
`ifdef CALC_MEM_RD_FWD_EN
    exp_fwd = 64'h22;
`else
    exp_fwd = 64'h11;
`endif
    wr(7, 64'h11); tick(); idle();
    wr(7, 64'h22); rd(7); tick(); idle();
    checks++; if (mem_if.r_data !== exp_fwd) $display("FAIL same_addr_rd: got %h expected %h", mem_if.r_data, exp_fwd); else passed++;
    rd(7); tick(); idle();
    checks++; if (mem_if.r_data !== 64'h22) $display("FAIL same_addr_after: got %h expected 22", mem_if.r_data); else passed++;
  endtask

  task automatic test_diff_addr;
    wr(8, 64'h33); rd(3); tick(); idle();
    checks++; if (mem_if.r_data !== 64'hDEAD_BEEF_0000_0001) $display("FAIL diff_addr_rd: got %h expected deadbeef00000001", mem_if.r_data); else passed++;
    rd(8); tick(); idle();
    checks++; if (mem_if.r_data !== 64'h33) $display("FAIL diff_addr_wr: got %h expected 33", mem_if.r_data); else passed++;
    checks++; if (rd_count !== 16'd6 || wr_count !== 16'd5) $display("FAIL diff_addr_counts: got %0d/%0d expected 6/5", rd_count, wr_count); else passed++;
    checks++; if (err_o !== 2'b00) $display("FAIL no_err: got %b expected 00", err_o); else passed++;
  endtask

  task automatic test_out_of_range;
    rd(1024); wr(1030, 64'hFF); tick(); idle();
    checks++; if (mem_if.r_data !== 64'h0 || mem_if.r_valid !== 1'b1) $display("FAIL oob_rd: got %h/%b expected 0/1", mem_if.r_data, mem_if.r_valid); else passed++;
    checks++; if (err_o !== 2'b01) $display("FAIL oob_err: got %b expected 01", err_o); else passed++;
    checks++; if (rd_count !== 16'd6 || wr_count !== 16'd5) $display("FAIL oob_counts: got %0d/%0d expected 6/5", rd_count, wr_count); else passed++;
    rd(6); tick(); idle();
    checks++; if (mem_if.r_data !== 64'h0) $display("FAIL oob_no_alias: got %h expected 0", mem_if.r_data); else passed++;
    checks++; if (err_o !== 2'b01) $display("FAIL err_sticky: got %b expected 01", err_o); else passed++;
  endtask

  task automatic test_busy_and_restart;
    int n;
    do_reset();
    repeat (10) tick();
    rd(3); tick(); idle();
    checks++; if (mem_if.r_valid !== 1'b0) $display("FAIL busy_rd_valid: got %b expected 0", mem_if.r_valid); else passed++;
    checks++; if (err_o !== 2'b10) $display("FAIL busy_err: got %b expected 10", err_o); else passed++;
    checks++; if (rd_count !== 16'd0 || busy_o !== 1'b1) $display("FAIL busy_state: got %0d/%b expected 0/1", rd_count, busy_o); else passed++;
    repeat (489) tick();
    rst_i = 1'b1; rd(4); wr(4, 64'h77); tick();
    rst_i = 1'b0; idle();
    checks++; if (err_o !== 2'b00 || busy_o !== 1'b1) $display("FAIL midsweep_rst: got %b/%b expected 00/1", err_o, busy_o); else passed++;
    wait_sweep(n);
    checks++; if (n != 1024) $display("FAIL restart_len: got %0d expected 1024", n); else passed++;
    checks++; if (err_o !== 2'b00 || wr_count !== 16'd0) $display("FAIL restart_clean: got %b/%0d expected 00/0", err_o, wr_count); else passed++;
    rd(1023); tick(); idle();
    checks++; if (mem_if.r_data !== 64'h0) $display("FAIL cleared_word: got %h expected 0", mem_if.r_data); else passed++;
  endtask

  task automatic test_reset_in_ready;
    wr(3, 64'h55); tick(); idle();
    rd(3); rst_i = 1'b1; tick();
    rst_i = 1'b0; idle();
    checks++; if (mem_if.r_valid !== 1'b0 || mem_if.r_data !== 64'h0) $display("FAIL rdy_rst_rd: got %b/%h expected 0/0", mem_if.r_valid, mem_if.r_data); else passed++;
    checks++; if (busy_o !== 1'b1 || rd_count !== 16'd0 || wr_count !== 16'd0) $display("FAIL rdy_rst_state: got %b/%0d/%0d expected 1/0/0", busy_o, rd_count, wr_count); else passed++;
  endtask

  initial begin
    rst_i = 1'b0;
    idle();
    test_reset();
    test_sweep();
    test_write_read();
    test_same_addr();
    test_diff_addr();
    test_out_of_range();
    test_busy_and_restart();
    test_reset_in_ready();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
